// File: rtl/resource_responder_if.sv
// Request/response bundle between resource_branch requesters and the responder.
// Each per-port field is packed with port p occupying slice [p*width +: width].
interface resource_responder_if #(
    parameter int DATA_WIDTH   = 16,
    parameter int HANDLE_WIDTH = 8,
    parameter int N_PORTS      = 4
);
    logic [N_PORTS-1:0]              read_req;
    logic [N_PORTS-1:0]              write_req;
    logic [N_PORTS*HANDLE_WIDTH-1:0] handle_in;
    logic [N_PORTS*DATA_WIDTH-1:0]   arg_a_in;
    logic [N_PORTS*DATA_WIDTH-1:0]   arg_b_in;
    logic [N_PORTS-1:0]              read_ready;
    logic [N_PORTS-1:0]              write_ack;
    logic signed [DATA_WIDTH-1:0]    data_out;

    modport master (
        output read_req, write_req, handle_in, arg_a_in, arg_b_in,
        input  read_ready, write_ack, data_out
    );

    modport slave (
        input  read_req, write_req, handle_in, arg_a_in, arg_b_in,
        output read_ready, write_ack, data_out
    );
endinterface

// File: rtl/resource_responder.sv
// Shared resource RAM server: round-robin arbitration across requesters, one
// transaction every three cycles (IDLE -> ACCESS -> RESP), one-cycle completions.
// The RAM is split into per-handle regions; out-of-range handles are acknowledged
// but never touch the RAM, and read back as zero.
module resource_responder #(
    parameter int DATA_WIDTH   = 16,
    parameter int HANDLE_WIDTH = 8,
    parameter int N_PORTS      = 4,
    parameter int N_HANDLES    = 16,
    parameter int DEPTH_WIDTH  = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    resource_responder_if.slave bus
);

    localparam int HIDX_W    = (N_HANDLES > 1) ? $clog2(N_HANDLES) : 1;
    localparam int ADDR_W    = HIDX_W + DEPTH_WIDTH;
    localparam int PORT_W    = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
    localparam int RAM_WORDS = 1 << ADDR_W;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t                       r_state;
    state_t                       w_state_next;
    logic [PORT_W-1:0]            r_rr_ptr;
    logic [PORT_W-1:0]            w_rr_ptr_next;
    logic [PORT_W-1:0]            r_port;
    logic [PORT_W-1:0]            w_port_next;
    logic                         r_is_write;
    logic                         w_is_write_next;
    logic                         r_oob;
    logic                         w_oob_next;
    logic [ADDR_W-1:0]            r_addr;
    logic [ADDR_W-1:0]            w_addr_next;
    logic signed [DATA_WIDTH-1:0] r_wdata;
    logic signed [DATA_WIDTH-1:0] w_wdata_next;
    logic signed [DATA_WIDTH-1:0] r_rdata;
    logic signed [DATA_WIDTH-1:0] w_rdata_next;
    logic signed [DATA_WIDTH-1:0] r_mem [RAM_WORDS];

    logic [N_PORTS-1:0]           w_req_any;
    logic [N_PORTS-1:0]           w_read_ready;
    logic [N_PORTS-1:0]           w_write_ack;
    int                           w_idx;
    logic                         w_grant_valid;
    logic [PORT_W-1:0]            w_grant_port;
    logic                         w_grant_write;
    logic [HANDLE_WIDTH-1:0]      w_grant_handle;
    logic [DEPTH_WIDTH-1:0]       w_grant_offset;
    logic [DATA_WIDTH-1:0]        w_grant_wdata;

    assign w_req_any = bus.read_req | bus.write_req;

    // Round-robin search: first requesting port at or after r_rr_ptr, cyclically.
    // A port with both read and write raised is served as a write.
    always_comb begin
        w_idx          = 0;
        w_grant_valid  = 1'b0;
        w_grant_port   = '0;
        w_grant_write  = 1'b0;
        w_grant_handle = '0;
        w_grant_offset = '0;
        w_grant_wdata  = '0;
        for (int k = 0; k < N_PORTS; k++) begin
            w_idx = int'(r_rr_ptr) + k;
            if (w_idx >= N_PORTS) begin
                w_idx = w_idx - N_PORTS;
            end
            if (!w_grant_valid && w_req_any[w_idx]) begin
                w_grant_valid  = 1'b1;
                w_grant_port   = PORT_W'(w_idx);
                w_grant_write  = bus.write_req[w_idx];
                w_grant_handle = bus.handle_in[w_idx*HANDLE_WIDTH +: HANDLE_WIDTH];
                w_grant_offset = bus.arg_a_in[w_idx*DATA_WIDTH +: DEPTH_WIDTH];
                w_grant_wdata  = bus.arg_b_in[w_idx*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Next-state logic and completion strobes; completions are decoded from RESP
    // so they vanish as soon as reset forces the FSM back to IDLE.
    always_comb begin
        w_state_next    = r_state;
        w_rr_ptr_next   = r_rr_ptr;
        w_port_next     = r_port;
        w_is_write_next = r_is_write;
        w_oob_next      = r_oob;
        w_addr_next     = r_addr;
        w_wdata_next    = r_wdata;
        w_rdata_next    = r_rdata;
        w_read_ready    = '0;
        w_write_ack     = '0;
        case (r_state)
            IDLE: begin
                if (w_grant_valid) begin
                    w_port_next     = w_grant_port;
                    w_is_write_next = w_grant_write;
                    w_oob_next      = (int'(w_grant_handle) >= N_HANDLES);
                    w_addr_next     = {w_grant_handle[HIDX_W-1:0], w_grant_offset};
                    w_wdata_next    = w_grant_wdata;
                    w_rr_ptr_next   = (w_grant_port == PORT_W'(N_PORTS - 1)) ?
                                      '0 : (w_grant_port + PORT_W'(1));
                    w_state_next    = ACCESS;
                end
            end
            ACCESS: begin
                if (!r_is_write) begin
                    w_rdata_next = r_oob ? '0 : r_mem[r_addr];
                end
                w_state_next = RESP;
            end
            RESP: begin
                if (r_is_write) begin
                    w_write_ack[r_port] = 1'b1;
                end else begin
                    w_read_ready[r_port] = 1'b1;
                end
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Control and transaction registers; everything freezes while enable is low.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_rr_ptr   <= '0;
            r_port     <= '0;
            r_is_write <= 1'b0;
            r_oob      <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rdata    <= '0;
        end else if (enable) begin
            r_state    <= w_state_next;
            r_rr_ptr   <= w_rr_ptr_next;
            r_port     <= w_port_next;
            r_is_write <= w_is_write_next;
            r_oob      <= w_oob_next;
            r_addr     <= w_addr_next;
            r_wdata    <= w_wdata_next;
            r_rdata    <= w_rdata_next;
        end
    end

    // Resource RAM write port; contents survive reset, out-of-range writes are dropped.
    always_ff @(posedge clk) begin
        if (enable && (r_state == ACCESS) && r_is_write && !r_oob) begin
            r_mem[r_addr] <= r_wdata;
        end
    end

    assign bus.read_ready = w_read_ready;
    assign bus.write_ack  = w_write_ack;
    assign bus.data_out   = r_rdata;

endmodule

// File: tb/tb_resource_responder.sv
// Scoreboard bench for resource_responder: each request pushes its expected
// completion (port, kind, data, cycle) and every completion seen is popped and checked.
module tb_resource_responder;

    localparam int DW = 16;
    localparam int HW = 8;
    localparam int NP = 4;

    typedef struct {
        int          port;
        bit          isWrite;
        logic [15:0] data;
        int          cycle;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    logic enable;
    int   cycle = 0;
    int   nChecks = 0;
    int   nFails = 0;
    int   pend [NP];
    exp_t expQ [$];
    logic [15:0] model [int];

    resource_responder_if #(.DATA_WIDTH(DW), .HANDLE_WIDTH(HW), .N_PORTS(NP)) bus ();

    resource_responder #(
        .DATA_WIDTH(DW), .HANDLE_WIDTH(HW), .N_PORTS(NP), .N_HANDLES(16), .DEPTH_WIDTH(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .bus(bus)
    );

    // Free-running clock and a cycle counter used to check completion latency.
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cycle <= cycle + 1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        nChecks++;
        if (observed !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", tag, observed, expected, cycle);
        end
    endtask

    task automatic driveReq(input int p, input bit rd, input bit wr, input logic [7:0] h,
                            input logic [15:0] a, input logic [15:0] b);
        bus.read_req[p]             = rd;
        bus.write_req[p]            = wr;
        bus.handle_in[p*HW +: HW]   = h;
        bus.arg_a_in[p*DW +: DW]    = a;
        bus.arg_b_in[p*DW +: DW]    = b;
    endtask

    // Raise a request and record what the responder must answer, and when.
    task automatic applyStimulus(input int p, input bit rd, input bit wr, input logic [7:0] h,
                                 input logic [15:0] a, input logic [15:0] b, input int latency);
        exp_t e;
        int   key;
        key       = int'(h[3:0]) * 256 + int'(a[7:0]);
        e.port    = p;
        e.isWrite = wr;
        e.cycle   = cycle + latency;
        e.data    = 16'h0000;
        if (wr) begin
            if (h < 8'd16) begin
                model[key] = b;
            end
        end else if (h < 8'd16 && model.exists(key)) begin
            e.data = model[key];
        end
        expQ.push_back(e);
        pend[p]++;
        driveReq(p, rd, wr, h, a, b);
    endtask

    task automatic sampleOutputs();
        exp_t e;
        if ((bus.read_ready | bus.write_ack) != '0) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected_ack", {24'h0, bus.read_ready, bus.write_ack}, 32'h0);
            end else begin
                e = expQ.pop_front();
                checkOutput("read_ready", {28'h0, bus.read_ready},
                            e.isWrite ? 32'h0 : (32'h1 << e.port));
                checkOutput("write_ack", {28'h0, bus.write_ack},
                            e.isWrite ? (32'h1 << e.port) : 32'h0);
                if (!e.isWrite) begin
                    checkOutput("data_out", {16'h0, $unsigned(bus.data_out)}, {16'h0, e.data});
                end
                checkOutput("ack_cycle", cycle, e.cycle);
                pend[e.port]--;
                if (pend[e.port] <= 0) begin
                    pend[e.port] = 0;
                    bus.read_req[e.port]  = 1'b0;
                    bus.write_req[e.port] = 1'b0;
                end
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        sampleOutputs();
    endtask

    function automatic int pendingTotal();
        int s = 0;
        for (int i = 0; i < NP; i++) s += pend[i];
        return s;
    endfunction

    // Run until every outstanding request is answered, then one idle cycle.
    task automatic waitForAcks(input int budget);
        int n = 0;
        while (pendingTotal() != 0 && n < budget) begin
            tick();
            n++;
        end
        if (pendingTotal() != 0) begin
            checkOutput("ack_timeout", pendingTotal(), 0);
            for (int i = 0; i < NP; i++) pend[i] = 0;
            bus.read_req  = '0;
            bus.write_req = '0;
            expQ.delete();
        end
        tick();
    endtask

    initial begin
        for (int i = 0; i < NP; i++) pend[i] = 0;
        reset         = 1'b0;
        enable        = 1'b1;
        bus.read_req  = '0;
        bus.write_req = '0;
        bus.handle_in = '0;
        bus.arg_a_in  = '0;
        bus.arg_b_in  = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset_read_ready", {28'h0, bus.read_ready}, 32'h0);
        checkOutput("reset_write_ack", {28'h0, bus.write_ack}, 32'h0);
        checkOutput("reset_data_out", {16'h0, $unsigned(bus.data_out)}, 32'h0);
        reset = 1'b1;

        // Basic write then read-back on port 0.
        applyStimulus(0, 1'b0, 1'b1, 8'd3, 16'd5, 16'h1234, 2);
        waitForAcks(20);
        applyStimulus(0, 1'b1, 1'b0, 8'd3, 16'd5, 16'h0000, 2);
        waitForAcks(20);

        // Region separation, offset wrap, and read+write on one port acting as write.
        applyStimulus(1, 1'b0, 1'b1, 8'd1, 16'h0000, 16'hAAAA, 2);
        waitForAcks(20);
        applyStimulus(2, 1'b1, 1'b1, 8'd2, 16'h0000, 16'h5555, 2);
        waitForAcks(20);
        applyStimulus(1, 1'b1, 1'b0, 8'd1, 16'h0100, 16'h0000, 2);
        waitForAcks(20);
        applyStimulus(3, 1'b1, 1'b0, 8'd2, 16'h0000, 16'h0000, 2);
        waitForAcks(20);

        // Out-of-range handle 20 aliases handle 4 in its low bits but must not write it.
        applyStimulus(2, 1'b0, 1'b1, 8'd4, 16'd5, 16'h4545, 2);
        waitForAcks(20);
        applyStimulus(2, 1'b0, 1'b1, 8'd20, 16'd5, 16'h7777, 2);
        waitForAcks(20);
        applyStimulus(2, 1'b1, 1'b0, 8'd4, 16'd5, 16'h0000, 2);
        waitForAcks(20);
        applyStimulus(2, 1'b1, 1'b0, 8'd20, 16'd5, 16'h0000, 2);
        waitForAcks(20);

        // Five disabled edges while in ACCESS delay the completion by five cycles.
        applyStimulus(0, 1'b1, 1'b0, 8'd3, 16'd5, 16'h0000, 7);
        tick();
        enable = 1'b0;
        repeat (5) tick();
        enable = 1'b1;
        waitForAcks(20);

        // Reset during a write's ACCESS cycle: no completion, RAM keeps the old value.
        driveReq(0, 1'b0, 1'b1, 8'd3, 16'd5, 16'hBEEF);
        tick();
        reset = 1'b0;
        #1;
        checkOutput("abort_read_ready", {28'h0, bus.read_ready}, 32'h0);
        checkOutput("abort_write_ack", {28'h0, bus.write_ack}, 32'h0);
        checkOutput("abort_data_out", {16'h0, $unsigned(bus.data_out)}, 32'h0);
        driveReq(0, 1'b0, 1'b0, 8'd0, 16'h0000, 16'h0000);
        repeat (2) tick();
        reset = 1'b1;
        repeat (3) tick();
        applyStimulus(3, 1'b1, 1'b0, 8'd3, 16'd5, 16'h0000, 2);
        waitForAcks(20);

        // All four ports at once, port 1 asking twice: order 0,1,2,3,1 with 3-cycle spacing.
        applyStimulus(0, 1'b1, 1'b0, 8'd3, 16'd5, 16'h0000, 2);
        applyStimulus(1, 1'b1, 1'b0, 8'd1, 16'd0, 16'h0000, 5);
        applyStimulus(2, 1'b1, 1'b0, 8'd2, 16'd0, 16'h0000, 8);
        applyStimulus(3, 1'b1, 1'b0, 8'd4, 16'd5, 16'h0000, 11);
        applyStimulus(1, 1'b1, 1'b0, 8'd1, 16'd0, 16'h0000, 14);
        waitForAcks(60);

        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
